ps2_keyboard_matrix: RTL and testbench



---
 rtl/ps2_keyboard_matrix.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ps2_keyboard_matrix.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 keyboard receiver feeding the C64 64-bit keyboard matrix mask.
// Ports: clk, rst (sync, active-high); i_ps2_clk/i_ps2_data raw async PS/2 lines;
//   o_keyboard_mask bit row*8+col set while held; o_code last byte received;
//   o_code_valid pulse on new byte; o_frame_err pulse on parity/start/stop/timeout.
module ps2_keyboard_matrix #(
    parameter int    TIMEOUT       = 8000,
    parameter string MEM_INIT_FILE = "ps2map.vh"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic [63:0] o_keyboard_mask,
    output logic [7:0]  o_code,
    output logic        o_code_valid,
    output logic        o_frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    // An empty map name selects a keyboard with no mapped keys.
    localparam bit MAP_EN = (MEM_INIT_FILE != "");

    // Scan code -> {mapped, row*8+col}; row = CIA PA bit, col = CIA PB bit.
    function automatic logic [6:0] lut(input logic [7:0] c);
        lut = 7'd0;
        case (c)
            8'h66: lut = {1'b1, 6'd0};   // Backspace -> INST/DEL
            8'h5A: lut = {1'b1, 6'd1};   // Enter -> RETURN
            8'h83: lut = {1'b1, 6'd3};   // F7
            8'h05: lut = {1'b1, 6'd4};   // F1
            8'h04: lut = {1'b1, 6'd5};   // F3
            8'h03: lut = {1'b1, 6'd6};   // F5
            8'h26: lut = {1'b1, 6'd8};   // 3
            8'h1D: lut = {1'b1, 6'd9};   // W
            8'h1C: lut = {1'b1, 6'd10};  // A
            8'h25: lut = {1'b1, 6'd11};  // 4
            8'h1A: lut = {1'b1, 6'd12};  // Z
            8'h1B: lut = {1'b1, 6'd13};  // S
            8'h24: lut = {1'b1, 6'd14};  // E
            8'h12: lut = {1'b1, 6'd15};  // LShift
            8'h2E: lut = {1'b1, 6'd16};  // 5
            8'h2D: lut = {1'b1, 6'd17};  // R
            8'h23: lut = {1'b1, 6'd18};  // D
            8'h36: lut = {1'b1, 6'd19};  // 6
            8'h21: lut = {1'b1, 6'd20};  // C
            8'h2B: lut = {1'b1, 6'd21};  // F
            8'h2C: lut = {1'b1, 6'd22};  // T
            8'h22: lut = {1'b1, 6'd23};  // X
            8'h3D: lut = {1'b1, 6'd24};  // 7
            8'h35: lut = {1'b1, 6'd25};  // Y
            8'h34: lut = {1'b1, 6'd26};  // G
            8'h3E: lut = {1'b1, 6'd27};  // 8
            8'h32: lut = {1'b1, 6'd28};  // B
            8'h33: lut = {1'b1, 6'd29};  // H
            8'h3C: lut = {1'b1, 6'd30};  // U
            8'h2A: lut = {1'b1, 6'd31};  // V
            8'h46: lut = {1'b1, 6'd32};  // 9
            8'h43: lut = {1'b1, 6'd33};  // I
            8'h3B: lut = {1'b1, 6'd34};  // J
            8'h45: lut = {1'b1, 6'd35};  // 0
            8'h3A: lut = {1'b1, 6'd36};  // M
            8'h42: lut = {1'b1, 6'd37};  // K
            8'h44: lut = {1'b1, 6'd38};  // O
            8'h31: lut = {1'b1, 6'd39};  // N
            8'h4D: lut = {1'b1, 6'd41};  // P
            8'h4B: lut = {1'b1, 6'd42};  // L
            8'h4E: lut = {1'b1, 6'd43};  // -
            8'h49: lut = {1'b1, 6'd44};  // .
            8'h52: lut = {1'b1, 6'd45};  // ' -> :
            8'h54: lut = {1'b1, 6'd46};  // [ -> @
            8'h41: lut = {1'b1, 6'd47};  // ,
            8'h5D: lut = {1'b1, 6'd48};  // \ -> pound
            8'h5B: lut = {1'b1, 6'd49};  // ] -> *
            8'h4C: lut = {1'b1, 6'd50};  // ;
            8'h59: lut = {1'b1, 6'd52};  // RShift
            8'h55: lut = {1'b1, 6'd53};  // =
            8'h4A: lut = {1'b1, 6'd55};  // /
            8'h16: lut = {1'b1, 6'd56};  // 1
            8'h0E: lut = {1'b1, 6'd57};  // ` -> left arrow
            8'h14: lut = {1'b1, 6'd58};  // LCtrl
            8'h1E: lut = {1'b1, 6'd59};  // 2
            8'h29: lut = {1'b1, 6'd60};  // Space
            8'h0D: lut = {1'b1, 6'd61};  // Tab -> C=
            8'h15: lut = {1'b1, 6'd62};  // Q
            8'h76: lut = {1'b1, 6'd63};  // Esc -> RUN/STOP
            default: lut = 7'd0;
        endcase
    endfunction

    // Synchronizers; idle-high reset values avoid a false edge out of reset.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= i_ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= i_ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Frame receiver
    logic [1:0]     state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [7:0]     sh_q, sh_d;
    logic           par_q, par_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [7:0]     code_q, code_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        wd_d    = wd_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (state_q != S_IDLE && wd_q == WD_LAST) begin
            // Gap reached TIMEOUT cycles: abandon the partial frame.
            state_d = S_IDLE;
            wd_d    = '0;
            err_d   = 1'b1;
        end else begin
            if (state_q != S_IDLE)
                wd_d = fall ? '0 : wd_q + WDW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_d = S_DATA;
                            cnt_d   = 3'd0;
                            wd_d    = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_DATA: begin
                        sh_d  = {dat_s2_q, sh_q[7:1]};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7)
                            state_d = S_PARITY;
                    end
                    S_PARITY: begin
                        par_d   = dat_s2_q;
                        state_d = S_STOP;
                    end
                    default: begin
                        state_d = S_IDLE;
                        wd_d    = '0;
                        if (dat_s2_q && (^sh_q ^ par_q)) begin
                            code_d  = sh_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            wd_q    <= wd_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Make/break decoder and matrix mask
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic        look_q, look_d;
    logic        lbrk_q, lbrk_d;
    logic        lext_q, lext_d;
    logic [6:0]  rom_q, rom_d;
    logic [63:0] mask_q, mask_d;

    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        look_d = 1'b0;
        lbrk_d = lbrk_q;
        lext_d = lext_q;
        rom_d  = rom_q;

        if (err_q) begin
            // A damaged frame may have been a prefix; forget both flags.
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else if (valid_q) begin
            case (code_q)
                8'hF0: brk_d = 1'b1;
                8'hE0: ext_d = 1'b1;
                8'hE1, 8'hAA: ;
                default: begin
                    rom_d  = MAP_EN ? lut(code_q) : 7'd0;
                    look_d = 1'b1;
                    lbrk_d = brk_q;
                    lext_d = ext_q;
                    brk_d  = 1'b0;
                    ext_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (look_q && rom_q[6] && !lext_q)
            mask_d[rom_q[5:0]] = ~lbrk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            look_q <= 1'b0;
            lbrk_q <= 1'b0;
            lext_q <= 1'b0;
            rom_q  <= '0;
            mask_q <= '0;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            look_q <= look_d;
            lbrk_q <= lbrk_d;
            lext_q <= lext_d;
            rom_q  <= rom_d;
            mask_q <= mask_d;
        end
    end

    assign o_keyboard_mask = mask_q;
    assign o_code          = code_q;
    assign o_code_valid    = valid_q;
    assign o_frame_err     = err_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: frames, prefixes, errors, timeout,
// reset; a negedge monitor counts pulses and mask changes.
module tb_ps2_keyboard_matrix;

    localparam int H = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [63:0] mask;
    logic [7:0]  code;
    logic        code_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          mask_chg = 0;
    int          valid_cyc = 0;
    int          mask_cyc = 0;
    int          vw = 0;
    int          vw_max = 0;
    logic [7:0]  last_code = 8'h00;
    logic [63:0] mask_prev = 64'h0;

    ps2_keyboard_matrix dut (
        .clk(clk),
        .rst(rst),
        .i_ps2_clk(ps2_clk),
        .i_ps2_data(ps2_data),
        .o_keyboard_mask(mask),
        .o_code(code),
        .o_code_valid(code_valid),
        .o_frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (code_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            last_code = code;
            vw = vw + 1;
            if (vw > vw_max) vw_max = vw;
        end else begin
            vw = 0;
        end
        if (frame_err === 1'b1) err_cnt = err_cnt + 1;
        if (mask !== mask_prev) begin
            mask_chg = mask_chg + 1;
            mask_cyc = cyc;
            mask_prev = mask;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic partial_frame(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        wait_cyc(5);
        n_checks++;
        if (mask !== 64'h0) begin
            n_fail++; $display("FAIL reset_mask got %h want 0", mask);
        end
        n_checks++;
        if ({code, code_valid, frame_err} !== 10'h0) begin
            n_fail++; $display("FAIL reset_outs got %h/%b/%b want 0", code, code_valid, frame_err);
        end
        rst = 1'b0;
        wait_cyc(20);
        n_checks++;
        if (valid_cnt + err_cnt !== 0) begin
            n_fail++; $display("FAIL reset_quiet got %0d pulses want 0", valid_cnt + err_cnt);
        end
    endtask

    task automatic test_make;
        int v0, m0;
        v0 = valid_cnt; m0 = mask_chg;
        send_frame(8'h1C, 0, 0);
        n_checks++;
        if (mask !== 64'h0000_0000_0000_0400) begin
            n_fail++; $display("FAIL make_mask got %h want 400", mask);
        end
        n_checks++;
        if (valid_cnt - v0 !== 1 || last_code !== 8'h1C || code !== 8'h1C) begin
            n_fail++; $display("FAIL make_code got %0d/%h want 1/1c", valid_cnt - v0, last_code);
        end
        n_checks++;
        if (vw_max !== 1) begin
            n_fail++; $display("FAIL valid_width got %0d want 1", vw_max);
        end
        n_checks++;
        if (mask_cyc - valid_cyc !== 2 || mask_chg - m0 !== 1) begin
            n_fail++; $display("FAIL make_latency got %0d/%0d want 2/1", mask_cyc - valid_cyc, mask_chg - m0);
        end
    endtask

    task automatic test_break;
        int v0;
        v0 = valid_cnt;
        send_frame(8'hF0, 0, 0);
        n_checks++;
        if (mask !== 64'h0000_0000_0000_0400) begin
            n_fail++; $display("FAIL prefix_nochange got %h want 400", mask);
        end
        send_frame(8'h1C, 0, 0);
        n_checks++;
        if (mask !== 64'h0 || valid_cnt - v0 !== 2) begin
            n_fail++; $display("FAIL break got %h/%0d want 0/2", mask, valid_cnt - v0);
        end
    endtask

    task automatic test_multi;
        send_frame(8'h12, 0, 0);
        send_frame(8'h29, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_8000) begin
            n_fail++; $display("FAIL multi_hold got %h want 1000000000008000", mask);
        end
        send_frame(8'hF0, 0, 0);
        send_frame(8'h12, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0000) begin
            n_fail++; $display("FAIL multi_release got %h want 1000000000000000", mask);
        end
    endtask

    task automatic test_parity;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h29, 1, 0);
        n_checks++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL parity_err got err %0d valid %0d want 1/0", err_cnt - e0, valid_cnt - v0);
        end
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0000) begin
            n_fail++; $display("FAIL parity_mask got %h want 1000000000000000", mask);
        end
        send_frame(8'h5A, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0002) begin
            n_fail++; $display("FAIL after_parity got %h want 1000000000000002", mask);
        end
    endtask

    task automatic test_start_err;
        int e0;
        e0 = err_cnt;
        ps2_bit(1'b1);
        wait_cyc(H);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL start_err got %0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        partial_frame(8'h66, 4);
        wait_cyc(7000);
        n_checks++;
        if (err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL timeout_early got %0d want 0", err_cnt - e0);
        end
        wait_cyc(1100);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL timeout_err got %0d want 1", err_cnt - e0);
        end
        send_frame(8'h66, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0003 || err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL after_timeout got %h want 1000000000000003", mask);
        end
    endtask

    task automatic test_extended;
        int v0;
        v0 = valid_cnt;
        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0003 || valid_cnt - v0 !== 2) begin
            n_fail++; $display("FAIL ext_ignore got %h/%0d want 1000000000000003/2", mask, valid_cnt - v0);
        end
        send_frame(8'h1C, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0403) begin
            n_fail++; $display("FAIL ext_cleared got %h want 1000000000000403", mask);
        end
    endtask

    task automatic test_prefix_err;
        int v0, m0;
        send_frame(8'hF0, 0, 0);
        send_frame(8'h5A, 0, 1);
        send_frame(8'h5A, 0, 0);
        n_checks++;
        if (mask !== 64'h1000_0000_0000_0403) begin
            n_fail++; $display("FAIL err_clears_brk got %h want 1000000000000403", mask);
        end
        v0 = valid_cnt; m0 = mask_chg;
        send_frame(8'h7E, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hE1, 0, 0);
        n_checks++;
        if (mask_chg - m0 !== 0 || valid_cnt - v0 !== 3 || last_code !== 8'hE1) begin
            n_fail++; $display("FAIL unmapped_noop got chg %0d valid %0d code %h want 0/3/e1", mask_chg - m0, valid_cnt - v0, last_code);
        end
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        n_checks++;
        if (mask !== 64'h0000_0000_0000_0403) begin
            n_fail++; $display("FAIL space_release got %h want 403", mask);
        end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        partial_frame(8'h29, 3);
        wait_cyc(10);
        v0 = valid_cnt; e0 = err_cnt;
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(9000);
        n_checks++;
        if (mask !== 64'h0 || code !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid got %h/%h want 0/0", mask, code);
        end
        n_checks++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL reset_mid_pulse got %0d/%0d want 0/0", valid_cnt - v0, err_cnt - e0);
        end
        send_frame(8'h1C, 0, 0);
        n_checks++;
        if (mask !== 64'h0000_0000_0000_0400 || valid_cnt - v0 !== 1) begin
            n_fail++; $display("FAIL reset_recover got %h/%0d want 400/1", mask, valid_cnt - v0);
        end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_multi;
        test_parity;
        test_start_err;
        test_timeout;
        test_extended;
        test_prefix_err;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
